// File: rtl/sync_state_machine_if.sv
// Bundle of signals between the pattern comparator / control side and the
// preamble/sync tracker. The master drives the sample strobe and the
// qualifiers; the slave (the tracker) returns status, count and pulses.
interface sync_state_machine_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             is_matching;
  logic             resync;
  logic             frame_err;
  logic             is_waiting;
  logic             is_waiting_ending;
  logic             is_running;
  logic [CNT_W-1:0] match_cnt;
  logic             sync_err;
  logic             lock_lost;

  modport master (
    output en, is_matching, resync, frame_err,
    input  is_waiting, is_waiting_ending, is_running, match_cnt, sync_err, lock_lost
  );

  modport slave (
    input  en, is_matching, resync, frame_err,
    output is_waiting, is_waiting_ending, is_running, match_cnt, sync_err, lock_lost
  );
endinterface

// File: rtl/sync_state_machine.sv
// Preamble/sync tracker for the serializer front end.
// Counts consecutive qualified is_matching samples. Sync (RUNNING) is declared
// when a preamble of at least MIN_MATCH samples ends. A preamble longer than
// MAX_MATCH is flagged with a one-cycle sync_err. resync restarts the search.
// Optional feature macro: SYNC_SM_LOCK_LOSS_EN adds a frame-error monitor in
// RUNNING that drops lock after LOSS_THRESH consecutive frame errors.
module sync_state_machine #(
  parameter int MIN_MATCH   = 4,
  parameter int MAX_MATCH   = 64,
  parameter int CNT_W       = 8,
  parameter int LOSS_THRESH = 3
) (
  input  logic clk,
  input  logic rst,
  sync_state_machine_if.slave bus
);

  typedef enum logic [1:0] {
    WAITING        = 2'd0,
    MATCHING       = 2'd1,
    WAITING_ENDING = 2'd2,
    RUNNING        = 2'd3
  } state_t;

  localparam logic [CNT_W:0] MIN_LIM = (CNT_W + 1)'(MIN_MATCH);
  localparam logic [CNT_W:0] MAX_LIM = (CNT_W + 1)'(MAX_MATCH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync_err_q, sync_err_d;

  // One extra bit so the MAX_MATCH comparison can never see a wrapped count.
  logic [CNT_W:0]   cnt_inc;
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

`ifdef SYNC_SM_LOCK_LOSS_EN
  localparam int LOSS_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
  localparam logic [LOSS_W:0] LOSS_LIM = (LOSS_W + 1)'(LOSS_THRESH);

  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lock_lost_q, lock_lost_d;
  logic [LOSS_W:0]   loss_inc;
  assign loss_inc = {1'b0, loss_q} + {{LOSS_W{1'b0}}, 1'b1};
`else
  // frame_err has no consumer when the lock-loss monitor is not built.
  logic unused_frame_err;
  assign unused_frame_err = bus.frame_err;
`endif

  // Next-state, next-count and pulse decode.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch
    // and the pulses fall back to 0 on any cycle that does not raise them.
    state_d    = state_q;
    cnt_d      = cnt_q;
    sync_err_d = 1'b0;
`ifdef SYNC_SM_LOCK_LOSS_EN
    loss_d      = loss_q;
    lock_lost_d = 1'b0;
`endif

    if (bus.resync) begin
      state_d = WAITING;
      cnt_d   = '0;
`ifdef SYNC_SM_LOCK_LOSS_EN
      loss_d  = '0;
`endif
    end else if (bus.en) begin
      case (state_q)
        WAITING: begin
          if (bus.is_matching) begin
            cnt_d   = CNT_W'(1);
            state_d = (MIN_MATCH == 1) ? WAITING_ENDING : MATCHING;
          end else begin
            cnt_d = '0;
          end
        end

        MATCHING: begin
          if (bus.is_matching) begin
            cnt_d = cnt_inc[CNT_W-1:0];
            if (cnt_inc >= MIN_LIM) state_d = WAITING_ENDING;
          end else begin
            // Short preamble: discard quietly and search again.
            state_d = WAITING;
            cnt_d   = '0;
          end
        end

        WAITING_ENDING: begin
          if (bus.is_matching) begin
            if (cnt_inc <= MAX_LIM) begin
              cnt_d = cnt_inc[CNT_W-1:0];
            end else begin
              state_d    = WAITING;
              cnt_d      = '0;
              sync_err_d = 1'b1;
            end
          end else begin
            // Preamble ended with a legal length; count keeps its length.
            state_d = RUNNING;
`ifdef SYNC_SM_LOCK_LOSS_EN
            loss_d  = '0;
`endif
          end
        end

        RUNNING: begin
`ifdef SYNC_SM_LOCK_LOSS_EN
          if (bus.frame_err) begin
            if (loss_inc >= LOSS_LIM) begin
              state_d     = WAITING;
              cnt_d       = '0;
              loss_d      = '0;
              lock_lost_d = 1'b1;
            end else begin
              loss_d = loss_inc[LOSS_W-1:0];
            end
          end else begin
            loss_d = '0;
          end
`endif
        end

        default: begin
          state_d = WAITING;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, count and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAITING;
      cnt_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sync_err_q <= sync_err_d;
    end
  end

`ifdef SYNC_SM_LOCK_LOSS_EN
  // Frame-error monitor registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_q      <= '0;
      lock_lost_q <= 1'b0;
    end else begin
      loss_q      <= loss_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign bus.lock_lost = lock_lost_q;
`else
  assign bus.lock_lost = 1'b0;
`endif

  assign bus.is_waiting        = (state_q == WAITING) || (state_q == MATCHING);
  assign bus.is_waiting_ending = (state_q == WAITING_ENDING);
  assign bus.is_running        = (state_q == RUNNING);
  assign bus.match_cnt         = cnt_q;
  assign bus.sync_err          = sync_err_q;

endmodule

// File: tb/tb_sync_state_machine.sv
// Self-checking bench for sync_state_machine (MIN_MATCH=4, MAX_MATCH=8).
// A run-length model (current run, synced flag, loss count) predicts every
// output each cycle; directed sequences pin the model with literal values.
module tb_sync_state_machine;

  localparam int MIN_MATCH   = 4;
  localparam int MAX_MATCH   = 8;
  localparam int CNT_W       = 8;
  localparam int LOSS_THRESH = 3;

  logic clk;
  logic rst;

  sync_state_machine_if #(.CNT_W(CNT_W)) bus ();

  sync_state_machine #(
    .MIN_MATCH  (MIN_MATCH),
    .MAX_MATCH  (MAX_MATCH),
    .CNT_W      (CNT_W),
    .LOSS_THRESH(LOSS_THRESH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: length of the current run of matches, whether sync has
  // been declared, and consecutive frame errors while synced.
  int m_run;
  bit m_sync;
  int m_loss;
  bit m_err;
  bit m_lost;

  always @(posedge clk or posedge rst) begin : model
    int r, l;
    bit s, e, lo;
    if (rst) begin
      m_run  <= 0;
      m_sync <= 1'b0;
      m_loss <= 0;
      m_err  <= 1'b0;
      m_lost <= 1'b0;
    end else begin
      r = m_run; s = m_sync; l = m_loss; e = 1'b0; lo = 1'b0;
      if (bus.resync) begin
        r = 0; s = 1'b0; l = 0;
      end else if (bus.en) begin
        if (s) begin
`ifdef SYNC_SM_LOCK_LOSS_EN
          if (bus.frame_err) begin
            l = l + 1;
            if (l >= LOSS_THRESH) begin
              s = 1'b0; r = 0; l = 0; lo = 1'b1;
            end
          end else begin
            l = 0;
          end
`endif
        end else if (bus.is_matching) begin
          if (r + 1 > MAX_MATCH) begin
            r = 0; e = 1'b1;
          end else begin
            r = r + 1;
          end
        end else if (r >= MIN_MATCH) begin
          s = 1'b1; l = 0;
        end else begin
          r = 0;
        end
      end
      m_run <= r; m_sync <= s; m_loss <= l; m_err <= e; m_lost <= lo;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("is_waiting",        bus.is_waiting,        32'(!m_sync && m_run < MIN_MATCH));
      check("is_waiting_ending", bus.is_waiting_ending, 32'(!m_sync && m_run >= MIN_MATCH));
      check("is_running",        bus.is_running,        32'(m_sync));
      check("match_cnt",         bus.match_cnt,         32'(m_run));
      check("sync_err",          bus.sync_err,          32'(m_err));
      check("lock_lost",         bus.lock_lost,         32'(m_lost));
    end
  end

  // Apply one sample, clock it, then check literal expectations.
  // st: 0 = waiting/matching, 1 = waiting_ending, 2 = running.
  task automatic step(input bit e, input bit m, input bit rs, input bit fe,
                      input int exp_cnt, input int st, input string tag);
    bus.en = e; bus.is_matching = m; bus.resync = rs; bus.frame_err = fe;
    @(posedge clk); #1;
    check({tag, " cnt"},  bus.match_cnt,         32'(exp_cnt));
    check({tag, " wait"}, bus.is_waiting,        32'(st == 0));
    check({tag, " we"},   bus.is_waiting_ending, 32'(st == 1));
    check({tag, " run"},  bus.is_running,        32'(st == 2));
  endtask

  initial begin
    bus.en = 1'b0; bus.is_matching = 1'b0; bus.resync = 1'b0; bus.frame_err = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset wait", bus.is_waiting, 32'd1);
    check("reset cnt",  bus.match_cnt,  32'd0);
    check("reset run",  bus.is_running | bus.is_waiting_ending | bus.sync_err | bus.lock_lost, 32'd0);

    // Preamble of five, then end -> RUNNING holding length 5.
    step(1, 1, 0, 0, 1, 0, "t1a");
    step(1, 1, 0, 0, 2, 0, "t1b");
    step(1, 1, 0, 0, 3, 0, "t1c");
    step(1, 1, 0, 0, 4, 1, "t1d");
    step(1, 1, 0, 0, 5, 1, "t1e");
    step(1, 0, 0, 0, 5, 2, "t1f");
    check("t1 sync_err", bus.sync_err, 32'd0);
    step(1, 1, 0, 0, 5, 2, "t1 ignore match");
    // Resync in RUNNING with a matching sample present.
    step(1, 1, 1, 0, 0, 0, "t5 resync");

    // Short preamble is discarded silently.
    step(1, 1, 0, 0, 1, 0, "t2a");
    step(1, 1, 0, 0, 2, 0, "t2b");
    step(1, 1, 0, 0, 3, 0, "t2c");
    step(1, 0, 0, 0, 0, 0, "t2d");
    check("t2 sync_err", bus.sync_err, 32'd0);

    // Over-long preamble: ninth match raises sync_err for one cycle.
    for (int i = 1; i <= 8; i++) step(1, 1, 0, 0, i, (i >= 4) ? 1 : 0, "t3 run");
    step(1, 1, 0, 0, 0, 0, "t3 ninth");
    check("t3 sync_err high", bus.sync_err, 32'd1);
    step(1, 0, 0, 0, 0, 0, "t3 after");
    check("t3 sync_err low", bus.sync_err, 32'd0);

    // Strobe gating: count only advances on en=1.
    step(1, 1, 0, 0, 1, 0, "t4 c1");
    step(0, 1, 0, 0, 1, 0, "t4 c2");
    step(1, 1, 0, 0, 2, 0, "t4 c3");
    step(0, 0, 0, 0, 2, 0, "t4 c4");
    step(1, 1, 0, 0, 3, 0, "t4 c5");
    step(0, 1, 0, 0, 3, 0, "t4 c6");
    step(1, 1, 0, 0, 4, 1, "t4 c7");
    step(1, 1, 1, 0, 0, 0, "t4 clear");

    // Asynchronous reset mid-MATCHING.
    step(1, 1, 0, 0, 1, 0, "t5 m1");
    step(1, 1, 0, 0, 2, 0, "t5 m2");
    bus.en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("t5 async wait", bus.is_waiting, 32'd1);
    check("t5 async cnt",  bus.match_cnt,  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Frame-error monitor in RUNNING.
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 0, i, (i >= 4) ? 1 : 0, "t6 pre");
    step(1, 0, 0, 0, 4, 2, "t6 lock");
    step(1, 0, 0, 1, 4, 2, "t6 fe1");
    step(1, 0, 0, 1, 4, 2, "t6 fe2");
    step(1, 0, 0, 0, 4, 2, "t6 fe0");
    step(1, 0, 0, 1, 4, 2, "t6 fe3");
    step(1, 0, 0, 1, 4, 2, "t6 fe4");
    check("t6 lost early", bus.lock_lost, 32'd0);
`ifdef SYNC_SM_LOCK_LOSS_EN
    step(1, 0, 0, 1, 0, 0, "t6 fe5");
    check("t6 lock_lost", bus.lock_lost, 32'd1);
    step(1, 0, 0, 0, 0, 0, "t6 after");
    check("t6 lock_lost low", bus.lock_lost, 32'd0);
`else
    step(1, 0, 0, 1, 4, 2, "t6 fe5");
    check("t6 lock_lost", bus.lock_lost, 32'd0);
`endif

    // Randomized traffic checked by the model each cycle.
    for (int i = 0; i < 3000; i++) begin
      bus.en          = ($urandom_range(0, 9) < 7);
      bus.is_matching = ($urandom_range(0, 9) != 0) ^ (i[7] & ($urandom_range(0, 3) == 0));
      bus.resync      = ($urandom_range(0, 99) < 2);
      bus.frame_err   = ($urandom_range(0, 9) < 4);
      @(posedge clk); #1;
    end

    bus.en = 1'b0; bus.resync = 1'b0;
    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
